// File: rtl/stall_pkg.sv
// Shared definitions for the stall-request controller: state and source encodings
// plus default parameter values.
package stall_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_COUNT = 2'd1,
    ST_HOLD  = 2'd2,
    ST_GUARD = 2'd3
  } stall_state_e;

  typedef enum logic [1:0] {
    SRC_NONE  = 2'b00,
    SRC_LDUSE = 2'b01,
    SRC_MC    = 2'b10,
    SRC_EXT   = 2'b11
  } stall_src_e;

  localparam int DEF_CNT_W      = 4;
  localparam int DEF_LD_USE_CYC = 1;
  localparam int DEF_MIN_RUN    = 1;
  localparam int DEF_PERF_W     = 16;

endpackage

// File: rtl/stall_perf_cnt.sv
// Saturating event counter with synchronous clear; clear wins over increment.
module stall_perf_cnt #(
  parameter int W = 16
) (
  input  logic         clk_in,
  input  logic         rst,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != {W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/stall_req_ctrl.sv
// Arbitrates memory wait, multi-cycle op and load-use stalls into a registered
// active-low stallb_en window, with a post-count guard window and a perf counter.
module stall_req_ctrl
  import stall_pkg::*;
#(
  parameter int CNT_W      = DEF_CNT_W,
  parameter int LD_USE_CYC = DEF_LD_USE_CYC,
  parameter int MIN_RUN    = DEF_MIN_RUN,
  parameter int PERF_W     = DEF_PERF_W
) (
  input  logic              clk_in,
  input  logic              rst,
  input  logic              ext_hold,
  input  logic              mc_start,
  input  logic [CNT_W-1:0]  mc_cycles,
  input  logic              ld_use,
  input  logic              perf_clr,
  output logic              stallb_en,
  output logic              stall_busy,
  output logic [1:0]        stall_src,
  output logic [PERF_W-1:0] stall_cycles
);

  localparam int RUN_W = (MIN_RUN > 1) ? $clog2(MIN_RUN) : 1;
  localparam logic [CNT_W-1:0] LD_CNT     = CNT_W'(LD_USE_CYC - 1);
  localparam logic [RUN_W-1:0] GUARD_LAST = (MIN_RUN > 0) ? RUN_W'(MIN_RUN - 1) : '0;

  stall_state_e     state_q, state_d;
  stall_src_e       cnt_src_q, cnt_src_d;
  stall_src_e       src_q, src_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [RUN_W-1:0] run_cnt_q, run_cnt_d;
  logic             stallb_en_q, stallb_en_d;
  logic             busy_q, busy_d;

  always_ff @(posedge clk_in) begin
    if (rst) begin
      state_q     <= ST_RUN;
      cnt_q       <= '0;
      run_cnt_q   <= '0;
      cnt_src_q   <= SRC_NONE;
      src_q       <= SRC_NONE;
      stallb_en_q <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      run_cnt_q   <= run_cnt_d;
      cnt_src_q   <= cnt_src_d;
      src_q       <= src_d;
      stallb_en_q <= stallb_en_d;
      busy_q      <= busy_d;
    end
  end

  // Requests are only arbitrated in RUN; a running count is never shortened by ext_hold.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    run_cnt_d = run_cnt_q;
    cnt_src_d = cnt_src_q;
    unique case (state_q)
      ST_RUN: begin
        if (ext_hold) begin
          state_d = ST_HOLD;
        end else if (mc_start && (mc_cycles != '0)) begin
          state_d   = ST_COUNT;
          cnt_d     = mc_cycles - 1'b1;
          cnt_src_d = SRC_MC;
        end else if (ld_use) begin
          state_d   = ST_COUNT;
          cnt_d     = LD_CNT;
          cnt_src_d = SRC_LDUSE;
        end
      end
      ST_COUNT: begin
        if (cnt_q == '0) begin
          if (ext_hold) begin
            state_d = ST_HOLD;
          end else if (MIN_RUN > 0) begin
            state_d   = ST_GUARD;
            run_cnt_d = '0;
          end else begin
            state_d = ST_RUN;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_HOLD: begin
        if (!ext_hold) begin
          state_d = ST_RUN;
        end
      end
      ST_GUARD: begin
        if (ext_hold) begin
          state_d = ST_HOLD;
        end else if (run_cnt_q == GUARD_LAST) begin
          state_d = ST_RUN;
        end else begin
          run_cnt_d = run_cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  // Outputs are decoded from the next state so they land in flops with the state.
  always_comb begin
    stallb_en_d = 1'b1;
    busy_d      = (state_d != ST_RUN);
    src_d       = SRC_NONE;
    unique case (state_d)
      ST_COUNT: begin
        stallb_en_d = 1'b0;
        src_d       = cnt_src_d;
      end
      ST_HOLD: begin
        stallb_en_d = 1'b0;
        src_d       = SRC_EXT;
      end
      default: begin
      end
    endcase
  end

  stall_perf_cnt #(
    .W(PERF_W)
  ) u_perf_cnt (
    .clk_in (clk_in),
    .rst    (rst),
    .clr_i  (perf_clr),
    .inc_i  (~stallb_en_q),
    .cnt_o  (stall_cycles)
  );

  assign stallb_en  = stallb_en_q;
  assign stall_busy = busy_q;
  assign stall_src  = src_q;

endmodule

// File: tb/tb_stall_req_ctrl.sv
// Scoreboard bench: a cycle-level stall-window model predicts outputs after every
// edge and a negedge monitor compares them against the controller.
module tb_stall_req_ctrl;

  localparam int CNT_W      = 4;
  localparam int LD_USE_CYC = 1;
  localparam int MIN_RUN    = 1;
  localparam int PERF_W     = 4;
  localparam int PERF_MAX   = (1 << PERF_W) - 1;

  typedef struct {
    logic              stallb;
    logic              busy;
    logic [1:0]        src;
    logic [PERF_W-1:0] perf;
  } exp_t;

  logic              clk_in = 1'b0;
  logic              rst;
  logic              ext_hold;
  logic              mc_start;
  logic [CNT_W-1:0]  mc_cycles;
  logic              ld_use;
  logic              perf_clr;
  logic              stallb_en;
  logic              stall_busy;
  logic [1:0]        stall_src;
  logic [PERF_W-1:0] stall_cycles;

  int   checks   = 0;
  int   failures = 0;
  exp_t expQ[$];
  bit   started  = 0;

  // Reference model: stall cycles still owed, guard cycles left, hold flag.
  int   owed      = 0;
  int   guardLeft = 0;
  bit   holding   = 0;
  int   srcM      = 0;
  int   perfM     = 0;
  bit   expStallb = 1;

  stall_req_ctrl #(
    .CNT_W(CNT_W), .LD_USE_CYC(LD_USE_CYC), .MIN_RUN(MIN_RUN), .PERF_W(PERF_W)
  ) dut (
    .clk_in(clk_in), .rst(rst), .ext_hold(ext_hold), .mc_start(mc_start),
    .mc_cycles(mc_cycles), .ld_use(ld_use), .perf_clr(perf_clr),
    .stallb_en(stallb_en), .stall_busy(stall_busy), .stall_src(stall_src),
    .stall_cycles(stall_cycles)
  );

  always #5 clk_in = ~clk_in;

  always @(posedge clk_in) begin
    exp_t e;
    if (rst) begin
      owed = 0; guardLeft = 0; holding = 0; srcM = 0; perfM = 0;
    end else begin
      if (perf_clr) perfM = 0;
      else if (!expStallb && perfM < PERF_MAX) perfM = perfM + 1;
      if (owed > 0) begin
        owed = owed - 1;
        if (owed == 0) begin
          if (ext_hold) holding = 1;
          else guardLeft = MIN_RUN;
        end
      end else if (holding) begin
        holding = ext_hold;
      end else if (guardLeft > 0) begin
        if (ext_hold) begin holding = 1; guardLeft = 0; end
        else guardLeft = guardLeft - 1;
      end else begin
        if (ext_hold) holding = 1;
        else if (mc_start && int'(mc_cycles) != 0) begin owed = int'(mc_cycles); srcM = 2; end
        else if (ld_use) begin owed = LD_USE_CYC; srcM = 1; end
      end
    end
    expStallb = !(owed > 0 || holding);
    e.stallb = expStallb;
    e.busy   = (owed > 0) || holding || (guardLeft > 0);
    e.src    = holding ? 2'b11 : (owed > 0) ? 2'(srcM) : 2'b00;
    e.perf   = PERF_W'(perfM);
    expQ.push_back(e);
    started = 1;
  end

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s got=%0h exp=%0h t=%0t", name, got, exp, $time);
    end
  endtask

  always @(negedge clk_in) begin
    exp_t e;
    if (started) begin
      if (expQ.size() == 0) begin
        checkOutput("queue_empty", 32'd1, 32'd0);
      end else begin
        e = expQ.pop_front();
        checkOutput("stallb_en",    32'(stallb_en),    32'(e.stallb));
        checkOutput("stall_busy",   32'(stall_busy),   32'(e.busy));
        checkOutput("stall_src",    32'(stall_src),    32'(e.src));
        checkOutput("stall_cycles", 32'(stall_cycles), 32'(e.perf));
      end
    end
  end

  task automatic applyStimulus(input logic r, input logic ext, input logic mc,
                               input logic [CNT_W-1:0] cyc, input logic ld,
                               input logic clr, input int n);
    for (int i = 0; i < n; i++) begin
      rst = r; ext_hold = ext; mc_start = mc; mc_cycles = cyc; ld_use = ld; perf_clr = clr;
      @(posedge clk_in);
      #1;
    end
  endtask

  initial begin
    // Reset with ext_hold high, then HOLD right after release.
    applyStimulus(1, 1, 0, 0, 0, 0, 2);
    applyStimulus(0, 1, 0, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 0, 0, 2);
    applyStimulus(0, 0, 0, 0, 0, 1, 1);
    // Multi-cycle stall of 3.
    applyStimulus(0, 0, 1, 4'd3, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 0, 0, 6);
    // Simultaneous requests, mc wins, then mc_cycles=0 lets ld_use win.
    applyStimulus(0, 0, 1, 4'd5, 1, 0, 1);
    applyStimulus(0, 0, 0, 0, 0, 0, 8);
    applyStimulus(0, 0, 1, 4'd0, 1, 0, 1);
    applyStimulus(0, 0, 0, 0, 0, 0, 4);
    // ld_use held through COUNT and GUARD, then ext_hold during GUARD.
    applyStimulus(0, 0, 0, 0, 1, 0, 3);
    applyStimulus(0, 0, 0, 0, 0, 0, 5);
    applyStimulus(0, 0, 0, 0, 1, 0, 1);
    applyStimulus(0, 0, 0, 0, 0, 0, 1);
    applyStimulus(0, 1, 0, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 0, 0, 4);
    // ext_hold arriving mid-count.
    applyStimulus(0, 0, 1, 4'd4, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 0, 0, 1);
    applyStimulus(0, 1, 0, 0, 0, 0, 6);
    applyStimulus(0, 0, 0, 0, 0, 0, 4);
    // Saturation, then clear during an active stall.
    applyStimulus(0, 1, 0, 0, 0, 0, 20);
    applyStimulus(0, 1, 0, 0, 0, 1, 1);
    applyStimulus(0, 0, 0, 0, 0, 0, 3);
    // Reset in the middle of a long count.
    applyStimulus(0, 0, 1, 4'd12, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 0, 0, 3);
    applyStimulus(1, 0, 0, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 0, 0, 3);
    for (int i = 0; i < 3000; i++) begin
      applyStimulus($urandom_range(0, 149) == 0, $urandom_range(0, 9) == 0,
                    $urandom_range(0, 3) == 0, CNT_W'($urandom_range(0, 15)),
                    $urandom_range(0, 3) == 0, $urandom_range(0, 31) == 0, 1);
    end
    applyStimulus(0, 0, 0, 0, 0, 0, 2);
    @(negedge clk_in);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/stall_req_ctrl.md
Name: stall_req_ctrl

Overview:
- Stall-request controller that produces the active-low `stallb_en` consumed by the pipeline clock-gating block.
- Arbitrates three stall sources and converts them into a registered `stallb_en` low window of precise length:
  - external memory wait (level)
  - multi-cycle execute op (counted)
  - load-use hazard (fixed length)
- Enforces a minimum run window between counted stalls.
- Keeps a saturating stalled-cycle counter for performance monitoring.
- Sits between the hazard/decode/memory logic and the clock gater.

Parameters:
- CNT_W, 4: width of the multi-cycle length input and the internal down-counter.
- LD_USE_CYC, 1: stall cycles issued for a load-use hazard (1..2^CNT_W-1).
- MIN_RUN, 1: cycles of `stallb_en`=1 guaranteed after a counted stall before another counted stall is accepted (0 disables).
- PERF_W, 16: width of the stalled-cycle performance counter.

Ports:
- clk_in  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- ext_hold  input  1  level memory/bus wait; stall while high.
- mc_start  input  1  multi-cycle execute op request (sampled only in RUN).
- mc_cycles  input  CNT_W  stall length for `mc_start`; 0 means no stall.
- ld_use  input  1  load-use hazard request (sampled only in RUN).
- perf_clr  input  1  synchronous clear of `stall_cycles`.
- stallb_en  output  1  registered; 0 = stall pipeline, 1 = run.
- stall_busy  output  1  high when state is not RUN.
- stall_src  output  2  00 none, 01 ld_use, 10 mc, 11 ext_hold; registered alongside `stallb_en`.
- stall_cycles  output  PERF_W  saturating count of cycles with `stallb_en`=0.

Behaviour:
- Clock and reset: one clock, `clk_in`. Reset is synchronous and active-high, on `rst`.
- Reset values:
  - state=RUN, `stallb_en`=1, `stall_busy`=0, `stall_src`=00
  - cnt=0, run_cnt=0, `stall_cycles`=0
- States: RUN, COUNT, HOLD, GUARD.
- RUN (`stallb_en`=1):
  - `ext_hold` → HOLD.
  - Else `mc_start` with `mc_cycles`≠0 → COUNT, cnt=`mc_cycles`-1, src=10.
  - Else `ld_use` → COUNT, cnt=LD_USE_CYC-1, src=01.
  - Priority is `ext_hold` > `mc_start` > `ld_use`. A losing request is dropped, and the requester must re-assert.
  - `mc_start` with `mc_cycles`=0 is ignored, so `ld_use` may win in the same cycle.
- Latency: a request sampled at edge t gives `stallb_en`=0 from just after edge t for exactly N cycles (N = `mc_cycles` or LD_USE_CYC).
- COUNT (`stallb_en`=0):
  - cnt decrements each cycle.
  - At cnt==0, next state is HOLD if `ext_hold`, else GUARD if MIN_RUN>0, else RUN.
  - `ext_hold` arriving mid-COUNT does not shorten or pause the count.
  - New `mc_start`/`ld_use` in COUNT are ignored.
- HOLD (`stallb_en`=0, src=11):
  - Remain while `ext_hold`=1.
  - On `ext_hold`=0, go to RUN with `stallb_en`=1 on the next cycle.
  - HOLD does not arm GUARD.
- GUARD (`stallb_en`=1, src=00):
  - run_cnt counts MIN_RUN cycles.
  - `mc_start`/`ld_use` are ignored.
  - `ext_hold` is always honoured: → HOLD immediately, and the guard is abandoned.
  - On run_cnt==MIN_RUN-1, → RUN.
- `stall_busy` = (state≠RUN), registered. Note that it is 1 in GUARD.
- `stall_cycles`:
  - +1 on every cycle where the registered `stallb_en`=0.
  - Saturates at all-ones and does not wrap.
  - `perf_clr` has priority over increment and sets the counter to 0.
- Requesters are frozen by the gated clocks during a stall. A request still high in the first RUN cycle after a stall is treated as a new request, so sources must deassert on acceptance (ld_use/mc_start are one-shot).
- Reset mid-stall forces `stallb_en`=1 and RUN on the next edge; pending counts are discarded.
- All outputs come directly from flops; there is no combinational path from inputs to `stallb_en`.

Decomposition:
- Shared package (stall_pkg):
  - state encoding (RUN=2'd0, COUNT=2'd1, HOLD=2'd2, GUARD=2'd3)
  - `stall_src` codes
  - default widths
- One natural sub-module: stall_perf_cnt, a saturating PERF_W counter with sync clear and increment enable, reused for other perf events.

Test Plan:
- Reset: `rst`=1 for 2 cycles with `ext_hold`=1 → `stallb_en`=1, `stall_cycles`=0, `stall_src`=00. On the first edge after release → HOLD.
- Multi-cycle stall: `mc_start`=1, `mc_cycles`=3 for one cycle in RUN → `stallb_en`=0 for exactly 3 cycles with src=10, then 1 cycle GUARD (MIN_RUN=1), then RUN. `stall_cycles`=3.
- Simultaneous requests: `ld_use`=1 and `mc_start`=1 (`mc_cycles`=5) in the same cycle → 5-cycle stall, src=10. Repeat with `mc_cycles`=0 → 1-cycle stall, src=01.
- GUARD behaviour: `ld_use` during GUARD → ignored, `stallb_en` stays 1. `ext_hold` during GUARD → `stallb_en`=0 next cycle, src=11.
- Hold during a count: `ext_hold` rises mid-COUNT (`mc_cycles`=4) and stays high 6 cycles total → COUNT completes its 4 cycles, then HOLD until `ext_hold` falls. `stallb_en` is continuous 0 with no 1-cycle glitch.
- Counter limits: PERF_W=4, hold `ext_hold` 20 cycles → `stall_cycles` saturates at 15. `perf_clr` plus an active stall in the same cycle → 0.
